// File: rtl/usb_protocol_fsm.sv
// USB host transaction engine: issues tokens/DATA0/handshakes, waits for replies, retries and times out.
// Optional PROTO_STATS_EN adds saturating retry/failure counters.
module usb_protocol_fsm #(
    parameter logic [6:0] DEV_ADDR     = 7'd5,
    parameter logic [3:0] MEMPAGE_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP    = 4'd8,
    parameter logic [7:0] HS_TIMEOUT   = 8'd255,
    parameter logic [3:0] MAX_ATTEMPTS = 4'd8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [2:0]  msg_type,
    input  logic [63:0] rw_dout,
    output logic        protocol_free,
    output logic        timeout,
    output logic [63:0] rw_din,
    output logic        tx_start,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
`ifdef PROTO_STATS_EN
    output logic [15:0] stat_retries,
    output logic [15:0] stat_fails,
`endif
    input  logic        rx_err
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        IDLE, TX_TOK, TX_DATA, WAIT_HS, RX_WAIT, TX_HS
    } state_t;

    state_t      state;
    logic [7:0]  timer;
    logic [3:0]  attempts;
    logic [3:0]  att_nxt;
    logic [63:0] rx_buf;
    logic        ack_pend;
    logic        hs_ok;
    logic        data_ok;
    logic        expired;
    logic        fail;
    logic        give_up;

    assign protocol_free = (state == IDLE);
    assign att_nxt       = attempts + 4'd1;
    assign hs_ok         = rx_valid && !rx_err && (rx_pid == PID_ACK);
    assign data_ok       = rx_valid && !rx_err && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1);
    assign expired       = (timer == HS_TIMEOUT);

    // A received packet always takes precedence over a timer expiry in the same cycle.
    always_comb begin
        fail = 1'b0;
        case (state)
            WAIT_HS: fail = rx_valid ? !hs_ok : expired;
            RX_WAIT: fail = !rx_valid && expired;
            TX_HS:   fail = tx_done && !ack_pend;
            default: fail = 1'b0;
        endcase
        give_up = fail && (att_nxt >= MAX_ATTEMPTS);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            timer    <= 8'd0;
            attempts <= 4'd0;
            timeout  <= 1'b0;
            rw_din   <= 64'd0;
            tx_start <= 1'b0;
            tx_pid   <= 4'd0;
            tx_addr  <= 7'd0;
            tx_endp  <= 4'd0;
            tx_data  <= 64'd0;
            rx_buf   <= 64'd0;
            ack_pend <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            if (fail)
                attempts <= att_nxt;
            case (state)
                IDLE: begin
                    if (msg_type != 3'b000 && msg_type != 3'b111) begin
                        tx_data  <= rw_dout;
                        attempts <= 4'd0;
                        timer    <= 8'd0;
                    end
                    case (msg_type)
                        3'b001, 3'b010, 3'b101, 3'b110: begin
                            state    <= TX_TOK;
                            tx_start <= 1'b1;
                            tx_pid   <= (msg_type == 3'b001 || msg_type == 3'b110) ? PID_IN : PID_OUT;
                            tx_addr  <= DEV_ADDR;
                            tx_endp  <= msg_type[2] ? DATA_ENDP : MEMPAGE_ENDP;
                        end
                        3'b011: begin
                            state    <= TX_DATA;
                            tx_start <= 1'b1;
                            tx_pid   <= PID_DATA0;
                        end
                        3'b100:  state <= RX_WAIT;
                        default: state <= IDLE;
                    endcase
                end
                TX_TOK: if (tx_done) state <= IDLE;
                TX_DATA: begin
                    if (tx_done) begin
                        state <= WAIT_HS;
                        timer <= 8'd0;
                    end
                end
                WAIT_HS: begin
                    if (hs_ok) begin
                        state <= IDLE;
                    end else if (give_up) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else if (fail) begin
                        // tx_data still holds the latched payload, so a resend just re-arms the encoder.
                        state    <= TX_DATA;
                        tx_start <= 1'b1;
                        tx_pid   <= PID_DATA0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RX_WAIT: begin
                    if (rx_valid) begin
                        state    <= TX_HS;
                        tx_start <= 1'b1;
                        ack_pend <= data_ok;
                        tx_pid   <= data_ok ? PID_ACK : PID_NAK;
                        if (data_ok)
                            rx_buf <= rx_data;
                    end else if (give_up) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else if (fail) begin
                        timer <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                TX_HS: begin
                    if (tx_done) begin
                        if (ack_pend) begin
                            rw_din <= rx_buf;
                            state  <= IDLE;
                        end else if (give_up) begin
                            state   <= IDLE;
                            timeout <= 1'b1;
                        end else begin
                            state <= RX_WAIT;
                            timer <= 8'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROTO_STATS_EN
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            stat_retries <= 16'd0;
            stat_fails   <= 16'd0;
        end else begin
            if (fail && stat_retries != 16'hFFFF)
                stat_retries <= stat_retries + 16'd1;
            if (give_up && stat_fails != 16'hFFFF)
                stat_fails <= stat_fails + 16'd1;
        end
    end
`endif

endmodule
